// File: rtl/uart_alu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_alu_ctrl_pkg                                             |
// | Purpose  : Shared types and constants for the UART/ALU sequencer:        |
// |            FSM state encoding, ALU opcode values, default widths.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package uart_alu_ctrl_pkg;

  localparam int C_DBIT_DEFAULT = 8;
  localparam int C_OP_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  // Opcodes understood by the companion ALU (MIPS funct style).
  localparam logic [5:0] C_OP_ADD = 6'h20;
  localparam logic [5:0] C_OP_SUB = 6'h22;
  localparam logic [5:0] C_OP_AND = 6'h24;
  localparam logic [5:0] C_OP_OR  = 6'h25;
  localparam logic [5:0] C_OP_XOR = 6'h26;
  localparam logic [5:0] C_OP_SRA = 6'h03;
  localparam logic [5:0] C_OP_SRL = 6'h02;
  localparam logic [5:0] C_OP_NOR = 6'h27;

endpackage
`default_nettype wire

// File: rtl/uart_alu_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_alu_ctrl_if                                              |
// | Purpose  : Bundle of the UART FIFO handshake and ALU operand/result      |
// |            signals seen by the sequencer.                                |
// |   master : sequencer side (pops RX, pushes TX, drives ALU operands)      |
// |   slave  : environment side (FIFOs + ALU)                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface uart_alu_ctrl_if
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT = C_DBIT_DEFAULT,
  parameter int OP_W = C_OP_W_DEFAULT
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd_uart;
  logic            tx_full;
  logic            wr_uart;
  logic [DBIT-1:0] w_data;
  logic [DBIT-1:0] alu_a;
  logic [DBIT-1:0] alu_b;
  logic [OP_W-1:0] alu_op;
  logic [DBIT-1:0] alu_result;
  logic            busy;
  logic            done_tick;
  logic            err_tmo;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy, done_tick, err_tmo
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy, done_tick, err_tmo
  );
endinterface
`default_nettype wire

// File: rtl/uart_alu_ctrl_frame_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frame_timer                                                   |
// | Purpose  : Inter-byte watchdog. Counts enabled cycles since the last     |
// |            clear and flags the cycle on which TMO_CYC cycles would be    |
// |            reached. TMO_CYC = 0 disables it.                             |
// | Ports    : clk, reset (async, active low), clear, enable -> expire       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module frame_timer #(
  parameter int TMO_CYC  = 500000,
  parameter int TMO_BITS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TMO_CYC == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = clk ^ reset ^ clear ^ enable;
      assign expire   = 1'b0;
    end else begin : g_enabled
      localparam logic [TMO_BITS-1:0] C_LAST = TMO_BITS'(TMO_CYC - 1);
      logic [TMO_BITS-1:0] r_count;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + TMO_BITS'(1);
        end
      end

      // Expiry is judged on the pre-increment count so the caller can act
      // on the same edge that would have made the count reach TMO_CYC.
      assign expire = enable && (r_count == C_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_alu_ctrl                                                 |
// | Purpose  : Sequencer between the UART FIFOs and a combinational ALU.     |
// |            Pops operand A, operand B and opcode from RX, lets the ALU    |
// |            settle for one cycle, captures its result and pushes it to    |
// |            TX. A frame stalled between bytes is dropped on timeout.      |
// | Ports    : clk, reset (async, active low)                                |
// |            bus (master): rx_empty, r_data, rd_uart, tx_full, wr_uart,    |
// |            w_data, alu_a, alu_b, alu_op, alu_result, busy, done_tick,    |
// |            err_tmo                                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT     = C_DBIT_DEFAULT,
  parameter int OP_W     = C_OP_W_DEFAULT,
  parameter int TMO_CYC  = 500000,
  parameter int TMO_BITS = 20
) (
  input logic           clk,
  input logic           reset,
  uart_alu_ctrl_if.master bus
);

  state_t          r_state;
  logic [DBIT-1:0] r_a;
  logic [DBIT-1:0] r_b;
  logic [OP_W-1:0] r_op;
  logic [DBIT-1:0] r_result;
  logic [DBIT-1:0] r_wdata;
  logic            r_rd;
  logic            r_wr;
  logic            r_done;
  logic            r_err;
  logic            r_busy;

  logic w_rx_ok;
  logic w_in_get;
  logic w_capture;
  logic w_tmr_en;
  logic w_tmr_clear;
  logic w_expire;

  // The FIFO status only reflects a pop one cycle later, so a byte may only
  // be taken when no pop is already in flight.
  assign w_rx_ok   = !bus.rx_empty && !r_rd;
  assign w_in_get  = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                     (r_state == ST_GET_OP);
  assign w_capture = w_in_get && w_rx_ok;

  // Only the gaps inside a frame are timed; waiting for the first byte or
  // for TX space never times out.
  assign w_tmr_en    = (r_state == ST_GET_B) || (r_state == ST_GET_OP);
  assign w_tmr_clear = w_capture || !w_tmr_en || w_expire;

  frame_timer #(
    .TMO_CYC (TMO_CYC),
    .TMO_BITS(TMO_BITS)
  ) u_frame_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_tmr_clear),
    .enable(w_tmr_en),
    .expire(w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_GET_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_wdata  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_GET_A: begin
          if (w_rx_ok) begin
            r_a     <= bus.r_data;
            r_rd    <= 1'b1;
            r_state <= ST_GET_B;
            r_busy  <= 1'b1;
          end
        end
        ST_GET_B: begin
          // A capture on the expiry cycle still completes the byte.
          if (w_rx_ok) begin
            r_b     <= bus.r_data;
            r_rd    <= 1'b1;
            r_state <= ST_GET_OP;
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= ST_GET_A;
            r_busy  <= 1'b0;
          end
        end
        ST_GET_OP: begin
          if (w_rx_ok) begin
            r_op    <= bus.r_data[OP_W-1:0];
            r_rd    <= 1'b1;
            r_state <= ST_EXEC;
          end else if (w_expire) begin
            r_err   <= 1'b1;
            r_state <= ST_GET_A;
            r_busy  <= 1'b0;
          end
        end
        ST_EXEC: begin
          // Operands have been stable for a full cycle by now.
          r_result <= bus.alu_result;
          r_state  <= ST_SEND;
        end
        ST_SEND: begin
          if (!bus.tx_full && !r_wr) begin
            r_wdata <= r_result;
            r_wr    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_GET_A;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_GET_A;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_uart   = r_rd;
  assign bus.wr_uart   = r_wr;
  assign bus.w_data    = r_wdata;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_op    = r_op;
  assign bus.busy      = r_busy;
  assign bus.done_tick = r_done;
  assign bus.err_tmo   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_alu_ctrl                                              |
// | Purpose  : Self-checking bench for uart_alu_ctrl: RX FIFO and ALU        |
// |            models, frame-level reference model, directed scenarios.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_alu_ctrl;
  import uart_alu_ctrl_pkg::*;

  localparam int DBIT = 8;
  localparam int OP_W = 6;
  localparam int TMO  = 16;
  localparam int TMOB = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic txf   = 1'b0;

  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.DBIT(DBIT), .OP_W(OP_W)) bus ();

  uart_alu_ctrl #(
    .DBIT(DBIT), .OP_W(OP_W), .TMO_CYC(TMO), .TMO_BITS(TMOB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ALU reference
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      C_OP_ADD: return a + b;
      C_OP_SUB: return a - b;
      C_OP_AND: return a & b;
      C_OP_OR:  return a | b;
      C_OP_XOR: return a ^ b;
      C_OP_NOR: return ~(a | b);
      C_OP_SRA: return sa >>> b;
      C_OP_SRL: return a >> b;
      default:  return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.tx_full    = txf;

  // RX FIFO: pop takes effect at the edge where rd_uart is seen high.
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.rx_empty = (wr_ptr == rd_ptr);
  assign bus.r_data   = fifo_mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (bus.rd_uart && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
  end

  // Frame-level reference model, evaluated mid-cycle.
  int         cyc = 0;
  int         n_pops = 0, n_push = 0, n_err = 0;
  int         last_pop_cyc = 0, last_err_cyc = 0, last_push_cyc = 0;
  int         m_partial = 0, m_gap = 0, m_ready = 0;
  bit         m_pending = 0, prev_rd = 0, txf_prev = 0;
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [5:0] m_op = 0;
  logic [7:0] out_q [$];

  initial forever begin
    bit exp_err, exp_wr;
    @(negedge clk);
    if (!reset) begin
      m_partial = 0; m_gap = 0; m_pending = 0; prev_rd = 0; txf_prev = 0;
      m_a = 0; m_b = 0; m_op = 0;
      chk("rst_rd", bus.rd_uart, 0);
      chk("rst_wr", bus.wr_uart, 0);
      chk("rst_wdata", bus.w_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done_tick, 0);
      chk("rst_err", bus.err_tmo, 0);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_op", bus.alu_op, 0);
    end else begin
      cyc++;
      exp_err = 0;
      if (bus.rd_uart) begin
        chk("pop_nonempty", bus.rx_empty, 0);
        chk("no_double_pop", prev_rd, 0);
        chk("no_pop_while_result", m_pending, 0);
        n_pops++;
        last_pop_cyc = cyc;
        case (m_partial)
          0:       m_a  = bus.r_data;
          1:       m_b  = bus.r_data;
          default: m_op = bus.r_data[5:0];
        endcase
        m_partial++;
        m_gap = 0;
        if (m_partial == 3) begin
          m_partial = 0;
          m_pending = 1;
          m_ready   = cyc + 2;
          m_res     = alu_fn(m_a, m_b, m_op);
        end
      end else if (m_partial != 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          exp_err   = 1;
          m_partial = 0;
          m_gap     = 0;
        end
      end
      exp_wr = m_pending && (cyc >= m_ready) && !txf_prev;
      chk("wr_uart", bus.wr_uart, exp_wr);
      chk("done_tick", bus.done_tick, exp_wr);
      chk("err_tmo", bus.err_tmo, exp_err);
      if (exp_wr) begin
        chk("w_data", bus.w_data, m_res);
        m_pending = 0;
      end
      if (bus.wr_uart) begin
        n_push++;
        last_push_cyc = cyc;
        out_q.push_back(bus.w_data);
      end
      if (bus.err_tmo) begin
        n_err++;
        last_err_cyc = cyc;
      end
      chk("busy", bus.busy, (m_partial != 0) || m_pending);
      chk("alu_a", bus.alu_a, m_a);
      chk("alu_b", bus.alu_b, m_b);
      chk("alu_op", bus.alu_op, m_op);
      prev_rd  = bus.rd_uart;
      txf_prev = txf;
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic int cnt(input int sel);
    case (sel)
      0:       return n_pops;
      1:       return n_push;
      default: return n_err;
    endcase
  endfunction

  // Bounded wait; a timeout shows up as a failed count comparison.
  task automatic wait_cnt(input int sel, input int target, input string name);
    for (int k = 0; k < 500 && cnt(sel) < target; k++) @(posedge clk);
    chk(name, cnt(sel), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int drop_cyc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: nominal ADD
    push(8'h05); push(8'h03); push(8'h20);
    wait_cnt(1, 1, "t1_push_count");
    chk("t1_result", out_q[0], 8'h08);
    repeat (3) @(posedge clk);
    chk("t1_pops", n_pops, 3);
    chk("t1_busy_idle", bus.busy, 0);

    // 2: back-to-back frames
    push(8'h0F); push(8'hF0); push(8'h25);
    push(8'hAA); push(8'h0F); push(8'h24);
    wait_cnt(1, 3, "t2_push_count");
    chk("t2_result0", out_q[1], 8'hFF);
    chk("t2_result1", out_q[2], 8'h0A);
    chk("t2_pops", n_pops, 9);

    // 3: TX backpressure while a result is waiting
    @(posedge clk); #1 txf = 1'b1;
    push(8'h30); push(8'h12); push(8'h22);
    wait_cnt(0, 12, "t3_pops_frame");
    push(8'h02); push(8'h03); push(8'h27);
    repeat (50) @(posedge clk);
    chk("t3_no_push", n_push, 3);
    chk("t3_no_pops", n_pops, 12);
    chk("t3_no_err", n_err, 0);
    @(posedge clk); #1 txf = 1'b0;
    drop_cyc = cyc;
    wait_cnt(1, 4, "t3_push_after_drop");
    chk("t3_push_latency", last_push_cyc - drop_cyc, 2);
    chk("t3_result", out_q[3], 8'h1E);
    wait_cnt(1, 5, "t3_second_push");
    chk("t3_result2", out_q[4], 8'hFC);

    // 4: partial frame timeout, then a fresh frame
    push(8'h07);
    wait_cnt(2, 1, "t4_err_count");
    chk("t4_err_latency", last_err_cyc - last_pop_cyc, 16);
    chk("t4_busy_idle", bus.busy, 0);
    push(8'h01); push(8'h01); push(8'h20);
    wait_cnt(1, 6, "t4_push_count");
    chk("t4_result", out_q[5], 8'h02);

    // 4b: byte arriving on the expiry cycle is captured, no timeout
    push(8'h07);
    wait_cnt(0, 20, "t4b_pop_a");
    repeat (14) @(posedge clk);
    #1;
    fifo_mem[wr_ptr[7:0]] = 8'h03;
    wr_ptr = wr_ptr + 1;
    push(8'h20);
    wait_cnt(1, 7, "t4b_push_count");
    chk("t4b_result", out_q[6], 8'h0A);
    chk("t4b_no_err", n_err, 1);

    // 5: reset in the middle of a frame
    push(8'h09); push(8'h04);
    wait_cnt(0, 24, "t5_pops_ab");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_alu_a", bus.alu_a, 0);
    chk("t5_rst_alu_b", bus.alu_b, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_wdata", bus.w_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push(8'h09); push(8'h04); push(8'h22);
    wait_cnt(1, 8, "t5_push_count");
    chk("t5_result", out_q[7], 8'h05);

    // 6: opcode bits above OP_W are ignored
    push(8'h0C); push(8'h06); push(8'hE0);
    wait_cnt(1, 9, "t6_push_count");
    chk("t6_alu_op", bus.alu_op, 6'h20);
    chk("t6_result", out_q[8], 8'h12);
    repeat (5) @(posedge clk);
    chk("t6_pops_total", n_pops, 30);
    chk("final_err_total", n_err, 1);
    chk("final_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
